// File: rtl/nor_lock_scan.sv
// NOR flash block-lock scanner: reads lock/lock-down status of consecutive blocks.
// Optional NOR_READ_ARRAY_RESTORE_EN returns the device to read-array mode at the end.
module nor_lock_scan #(
  parameter int          NUM_BLOCKS   = 8,
  parameter logic [23:0] BASE_ADDR    = 24'h3F0000,
  parameter logic [23:0] BLOCK_STRIDE = 24'h010000,
  parameter int          T_STROBE     = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [NUM_BLOCKS-1:0] LOCK_MAP,
  output logic [NUM_BLOCKS-1:0] LOCKDOWN_MAP,
  output logic [7:0]            SHOW,
  output logic [23:0]           ADDR,
  inout  wire  [15:0]           DATA,
  output logic                  CE,
  output logic                  WE,
  output logic                  OE
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SETUP     = 4'd1;
  localparam logic [3:0] S_CMD_WR    = 4'd2;
  localparam logic [3:0] S_CMD_HOLD  = 4'd3;
  localparam logic [3:0] S_RD        = 4'd4;
  localparam logic [3:0] S_RECOVER   = 4'd5;
  localparam logic [3:0] S_DONE      = 4'd6;
`ifdef NOR_READ_ARRAY_RESTORE_EN
  localparam logic [3:0] S_RST_SETUP = 4'd7;
  localparam logic [3:0] S_RST_WR    = 4'd8;
  localparam logic [3:0] S_RST_HOLD  = 4'd9;
`endif

  localparam logic [3:0] T_LOAD = 4'(T_STROBE - 1);
  localparam logic [5:0] LAST   = 6'(NUM_BLOCKS - 1);
  localparam logic [NUM_BLOCKS-1:0] ONE = NUM_BLOCKS'(1);

  logic [3:0]            state;
  logic [3:0]            cnt;
  logic [5:0]            idx;
  logic [23:0]           base_q;
  logic [NUM_BLOCKS-1:0] lock_q;
  logic [NUM_BLOCKS-1:0] down_q;
  logic [NUM_BLOCKS-1:0] mask;
  logic                  drv;
  logic [15:0]           dout;
  logic                  unused_data;

  assign mask        = ONE << idx;
  assign unused_data = ^DATA[15:2];

  // Sequencer: command write, status read, advance block
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      base_q <= BASE_ADDR;
      lock_q <= '0;
      down_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            lock_q <= '0;
            down_q <= '0;
            idx    <= '0;
            base_q <= BASE_ADDR;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt   <= T_LOAD;
          state <= S_CMD_WR;
        end
        S_CMD_WR: begin
          if (cnt == 4'd0) state <= S_CMD_HOLD;
          else cnt <= cnt - 4'd1;
        end
        S_CMD_HOLD: begin
          cnt   <= T_LOAD;
          state <= S_RD;
        end
        S_RD: begin
          if (cnt == 4'd0) begin
            if (DATA[0]) lock_q <= lock_q | mask;
            if (DATA[1]) down_q <= down_q | mask;
            state <= S_RECOVER;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RECOVER: begin
          if (idx < LAST) begin
            idx    <= idx + 6'd1;
            base_q <= base_q + BLOCK_STRIDE;
            state  <= S_SETUP;
          end else begin
`ifdef NOR_READ_ARRAY_RESTORE_EN
            state <= S_RST_SETUP;
`else
            state <= S_DONE;
`endif
          end
        end
`ifdef NOR_READ_ARRAY_RESTORE_EN
        S_RST_SETUP: begin
          cnt   <= T_LOAD;
          state <= S_RST_WR;
        end
        S_RST_WR: begin
          if (cnt == 4'd0) state <= S_RST_HOLD;
          else cnt <= cnt - 4'd1;
        end
        S_RST_HOLD: state <= S_DONE;
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus strobes, address and data drive decoded from state
  always_comb begin
    CE   = 1'b1;
    WE   = 1'b1;
    OE   = 1'b1;
    drv  = 1'b0;
    dout = 16'h0090;
    ADDR = base_q;
    unique case (state)
      S_SETUP, S_CMD_HOLD: drv = 1'b1;
      S_CMD_WR: begin
        CE  = 1'b0;
        WE  = 1'b0;
        drv = 1'b1;
      end
      S_RD: begin
        ADDR = base_q + 24'd2;
        CE   = 1'b0;
        OE   = 1'b0;
      end
      S_RECOVER: ADDR = base_q + 24'd2;
`ifdef NOR_READ_ARRAY_RESTORE_EN
      S_RST_SETUP, S_RST_HOLD: begin
        ADDR = BASE_ADDR;
        drv  = 1'b1;
        dout = 16'h00FF;
      end
      S_RST_WR: begin
        ADDR = BASE_ADDR;
        CE   = 1'b0;
        WE   = 1'b0;
        drv  = 1'b1;
        dout = 16'h00FF;
      end
`endif
      default: ;
    endcase
  end

  assign DATA         = drv ? dout : 16'hzzzz;
  assign BUSY         = (state != S_IDLE);
  assign DONE         = (state == S_DONE);
  assign LOCK_MAP     = lock_q;
  assign LOCKDOWN_MAP = down_q;
  assign SHOW         = 8'(lock_q);

endmodule

// File: tb/tb_nor_lock_scan.sv
// Directed bench for nor_lock_scan with a behavioural flash status model.
// Build with or without NOR_READ_ARRAY_RESTORE_EN.
module tb_nor_lock_scan;

`ifdef NOR_READ_ARRAY_RESTORE_EN
  localparam int LAT = 95;
  localparam int NW1 = 9;
  localparam int NW2 = 3;
`else
  localparam int LAT = 89;
  localparam int NW1 = 8;
  localparam int NW2 = 2;
`endif
  localparam int TS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [7:0]  lock_map, down_map, show;
  logic [23:0] addr;
  tri   [15:0] data;
  logic        ce, we, oe;

  logic        start2 = 1'b0;
  logic        busy2, done2;
  logic [1:0]  lock2, down2;
  logic [7:0]  show2;
  logic [23:0] addr2;
  tri   [15:0] data2;
  logic        ce2, we2, oe2;

  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nor_lock_scan u1 (
    .CLK(clk), .RESET(rst), .START(start), .BUSY(busy), .DONE(done),
    .LOCK_MAP(lock_map), .LOCKDOWN_MAP(down_map), .SHOW(show),
    .ADDR(addr), .DATA(data), .CE(ce), .WE(we), .OE(oe)
  );

  nor_lock_scan #(
    .NUM_BLOCKS(2), .BASE_ADDR(24'hFF8000), .BLOCK_STRIDE(24'h010000)
  ) u2 (
    .CLK(clk), .RESET(rst), .START(start2), .BUSY(busy2), .DONE(done2),
    .LOCK_MAP(lock2), .LOCKDOWN_MAP(down2), .SHOW(show2),
    .ADDR(addr2), .DATA(data2), .CE(ce2), .WE(we2), .OE(oe2)
  );

  // flash model: block status at base+2
  logic [15:0] st [8];
  logic [7:0]  hb;
  logic [15:0] rdv;
  initial begin
    st[0] = 16'h0001; st[1] = 16'h0000; st[2] = 16'h0003; st[3] = 16'h0000;
    st[4] = 16'h0000; st[5] = 16'h0000; st[6] = 16'h0000; st[7] = 16'h0001;
  end
  assign hb    = addr[23:16] - 8'h3F;
  assign rdv   = (addr[15:0] == 16'h0002) ? st[hb[2:0]] : 16'hFFFF;
  assign data  = (!ce && !oe) ? rdv : 16'hzzzz;
  assign data2 = (!ce2 && !oe2) ? 16'h0002 : 16'hzzzz;

  // write log for u1
  int          wlen = 0;
  int          nw = 0;
  logic [15:0] wd;
  logic [23:0] wa;
  logic [15:0] wq_d [16];
  logic [23:0] wq_a [16];
  always @(negedge clk) begin
    if (rst) begin
      wlen = 0;
    end else begin
      if (!oe && !we) begin
        fails++;
        $display("FAIL bus_oe_we: OE=%b WE=%b both low", oe, we);
      end
      if (!we) begin
        wlen++;
        wd = data;
        wa = addr;
      end else if (wlen != 0) begin
        vectors++;
        if (wlen !== TS) begin
          fails++;
          $display("FAIL we_width: got %0d cycles, expected %0d", wlen, TS);
        end
        if (nw < 16) begin
          wq_d[nw] = wd;
          wq_a[nw] = wa;
        end
        nw++;
        wlen = 0;
      end
    end
  end

  // write/read address log for u2
  int          w2len = 0;
  int          nw2 = 0;
  int          nr2 = 0;
  logic        oe2_low = 1'b0;
  logic [23:0] w2a [8];
  logic [23:0] r2a [8];
  always @(negedge clk) begin
    if (rst) begin
      w2len = 0;
      oe2_low = 1'b0;
    end else begin
      if (!we2) begin
        if (w2len == 0 && nw2 < 8) w2a[nw2] = addr2;
        w2len++;
      end else if (w2len != 0) begin
        nw2++;
        w2len = 0;
      end
      if (!oe2 && !oe2_low) begin
        if (nr2 < 8) r2a[nr2] = addr2;
        nr2++;
      end
      oe2_low = !oe2;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, ce, we, oe} !== 5'b00111) begin
      fails++;
      $display("FAIL reset_ctl: got %b expected 00111", {busy, done, ce, we, oe});
    end
    vectors++;
    if ({lock_map, down_map, show} !== 24'h0) begin
      fails++;
      $display("FAIL reset_maps: got %h expected 000000", {lock_map, down_map, show});
    end
    vectors++;
    if (addr !== 24'h3F0000) begin
      fails++;
      $display("FAIL reset_addr: got %h expected 3f0000", addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scan;
    int cyc;
    nw = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 start = 1'b0;
    @(negedge clk);
    while (!done && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    vectors++;
    if (cyc !== LAT) begin
      fails++;
      $display("FAIL scan_latency: got %0d expected %0d", cyc, LAT);
    end
    vectors++;
    if (lock_map !== 8'h85 || show !== 8'h85) begin
      fails++;
      $display("FAIL scan_lock: got %h/%h expected 85/85", lock_map, show);
    end
    vectors++;
    if (down_map !== 8'h04) begin
      fails++;
      $display("FAIL scan_lockdown: got %h expected 04", down_map);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done=%b busy=%b expected 0 0", done, busy);
    end
    vectors++;
    if (nw !== NW1) begin
      fails++;
      $display("FAIL write_count: got %0d expected %0d", nw, NW1);
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (wq_d[k] !== 16'h0090 || wq_a[k] !== 24'h3F0000 + 24'(k) * 24'h010000) begin
        fails++;
        $display("FAIL cmd_write%0d: got %h@%h expected 0090@%h",
                 k, wq_d[k], wq_a[k], 24'h3F0000 + 24'(k) * 24'h010000);
      end
    end
`ifdef NOR_READ_ARRAY_RESTORE_EN
    vectors++;
    if (wq_d[8] !== 16'h00FF || wq_a[8] !== 24'h3F0000) begin
      fails++;
      $display("FAIL restore_write: got %h@%h expected 00ff@3f0000", wq_d[8], wq_a[8]);
    end
`endif
    repeat (10) @(negedge clk);
    vectors++;
    if (lock_map !== 8'h85 || down_map !== 8'h04) begin
      fails++;
      $display("FAIL maps_hold: got %h/%h expected 85/04", lock_map, down_map);
    end
  endtask

  task automatic test_midreset;
    int n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(addr == 24'h420002 && !oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 200) begin
      fails++;
      $display("FAIL reach_rd3: timeout after %0d cycles", n);
    end
    vectors++;
    if (lock_map !== 8'h05) begin
      fails++;
      $display("FAIL partial_map: got %h expected 05", lock_map);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({ce, we, oe, busy, done} !== 5'b11100) begin
      fails++;
      $display("FAIL abort_ctl: got %b expected 11100", {ce, we, oe, busy, done});
    end
    vectors++;
    if ({lock_map, down_map, addr} !== {16'h0, 24'h3F0000}) begin
      fails++;
      $display("FAIL abort_state: got %h/%h/%h expected 00/00/3f0000",
               lock_map, down_map, addr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL no_autostart: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int nd;
    int t [3];
    logic prev;
    nd = 0;
    n = 0;
    prev = 1'b0;
    @(negedge clk);
    start = 1'b1;
    while (nd < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (prev) begin
          fails++;
          $display("FAIL done_width: DONE high two cycles at %0d", n);
        end else begin
          t[nd] = n;
          nd++;
        end
      end
      prev = done;
    end
    start = 1'b0;
    vectors++;
    if (nd !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d DONE pulses expected 3", nd);
    end else begin
      vectors++;
      if (t[1] - t[0] !== LAT + 1 || t[2] - t[1] !== LAT + 1) begin
        fails++;
        $display("FAIL b2b_period: got %0d,%0d expected %0d",
                 t[1] - t[0], t[2] - t[1], LAT + 1);
      end
    end
    vectors++;
    if (lock_map !== 8'h85 || down_map !== 8'h04) begin
      fails++;
      $display("FAIL b2b_maps: got %h/%h expected 85/04", lock_map, down_map);
    end
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_wrap;
    int n;
    nw2 = 0;
    nr2 = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    vectors++;
    if (nw2 !== NW2 || nr2 !== 2) begin
      fails++;
      $display("FAIL wrap_counts: got w%0d r%0d expected w%0d r2", nw2, nr2, NW2);
    end
    vectors++;
    if (w2a[0] !== 24'hFF8000 || w2a[1] !== 24'h008000) begin
      fails++;
      $display("FAIL wrap_cmd_addr: got %h,%h expected ff8000,008000", w2a[0], w2a[1]);
    end
    vectors++;
    if (r2a[0] !== 24'hFF8002 || r2a[1] !== 24'h008002) begin
      fails++;
      $display("FAIL wrap_rd_addr: got %h,%h expected ff8002,008002", r2a[0], r2a[1]);
    end
    vectors++;
    if (lock2 !== 2'b00 || down2 !== 2'b11 || show2 !== 8'h00) begin
      fails++;
      $display("FAIL wrap_maps: got %b/%b/%h expected 00/11/00", lock2, down2, show2);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midreset();
    test_scan();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
